// File: rtl/calc_pkg.sv
// Shared calculator definitions: encoder FSM states and the chord-to-opcode map
// used by the button encoder and any future decoder users.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        ISSUE    = 2'd2,
        WAIT_REL = 2'd3
    } state_e;

    typedef logic [2:0] chord_t;   // {c, l, r}
    typedef logic [3:0] opcode_t;

    function automatic opcode_t chord_to_op(input chord_t c);
        case (c)
            3'b000:  return 4'b0010;
            3'b001:  return 4'b0110;
            3'b010:  return 4'b1101;
            3'b011:  return 4'b0111;
            3'b100:  return 4'b0000;
            3'b101:  return 4'b0001;
            3'b110:  return 4'b1001;
            default: return 4'b1010;
        endcase
    endfunction

    // Width of a counter that must hold 0..n, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return ($clog2(n + 1) < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a debounce counter; the stable output flips
// only after the synchronised input has disagreed for DEBOUNCE_CYCLES cycles.
module btn_debounce
    import calc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic stable_o
);
    localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // NOTE: registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[0], btn_i};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/calc_btn_encoder.sv
// Debounces chord and enter buttons, accumulates the chord and issues one
// registered alu_op with a single-cycle op_valid per enter press.
module calc_btn_encoder
    import calc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnc,
    input  logic       btnl,
    input  logic       btnr,
    input  logic       btnd,
    output logic [3:0] alu_op,
    output logic       op_valid,
    output logic [2:0] chord
);
    localparam int unsigned   TW         = cnt_width(TIMEOUT_CYCLES);
    localparam int unsigned   TMO_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [TW-1:0] TMO_LAST   = TW'(TMO_LAST_I);
    localparam bit            TMO_EN     = (TIMEOUT_CYCLES != 0);

    logic [3:0] raw_btn;
    logic [3:0] stable_btn;   // {d, c, l, r}

    assign raw_btn = {btnd, btnc, btnl, btnr};

    for (genvar i = 0; i < 4; i++) begin : g_db
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk     (clk),
            .rst     (rst),
            .btn_i   (raw_btn[i]),
            .stable_o(stable_btn[i])
        );
    end

    state_e        state_q, state_d;
    chord_t        chord_q, chord_d;
    opcode_t       alu_op_q, alu_op_d;
    logic          op_valid_q, op_valid_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          enter_prev_q;

    chord_t held;
    logic   enter_evt;
    logic   timeout_hit;

    assign held        = stable_btn[2:0];
    assign enter_evt   = stable_btn[3] & ~enter_prev_q;
    assign timeout_hit = TMO_EN && (state_q == ARMED) && (held == '0) && (tmo_q == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enter_evt)          state_d = ISSUE;
                else if (held != '0)    state_d = ARMED;
            end
            ARMED: begin
                if (enter_evt)          state_d = ISSUE;
                else if (timeout_hit)   state_d = IDLE;
            end
            ISSUE:                      state_d = WAIT_REL;
            default: begin
                if (stable_btn == '0)   state_d = IDLE;
            end
        endcase
    end

    // The opcode is captured on the edge that enters ISSUE, so op_valid is high
    // exactly while the FSM sits in ISSUE.
    always_comb begin
        chord_d    = chord_q;
        alu_op_d   = alu_op_q;
        op_valid_d = 1'b0;
        tmo_d      = '0;
        if (state_q == IDLE || state_q == ARMED) begin
            if (enter_evt) begin
                alu_op_d   = chord_to_op(chord_q | held);
                op_valid_d = 1'b1;
                chord_d    = '0;
            end else if (timeout_hit) begin
                chord_d = '0;
            end else begin
                chord_d = chord_q | held;
                if (TMO_EN && state_q == ARMED && held == '0) tmo_d = tmo_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chord_q      <= '0;
            alu_op_q     <= '0;
            op_valid_q   <= 1'b0;
            tmo_q        <= '0;
            enter_prev_q <= 1'b0;
        end else begin
            chord_q      <= chord_d;
            alu_op_q     <= alu_op_d;
            op_valid_q   <= op_valid_d;
            tmo_q        <= tmo_d;
            enter_prev_q <= stable_btn[3];
        end
    end

    assign alu_op   = alu_op_q;
    assign op_valid = op_valid_q;
    assign chord    = chord_q;

endmodule

// File: tb/tb_calc_btn_encoder.sv
// Directed bench for calc_btn_encoder: a chord table plus hand-written
// sequences for latency, glitch, timeout, reset and release corner cases.
module tb_calc_btn_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btnc = 1'b0, btnl = 1'b0, btnr = 1'b0, btnd = 1'b0;

    logic [3:0] alu_op0, alu_op1;
    logic       op_valid0, op_valid1;
    logic [2:0] chord0, chord1;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses0  = 0;
    int pulses1  = 0;

    always #5 clk = ~clk;

    calc_btn_encoder #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(0)) u_dut (
        .clk(clk), .rst(rst), .btnc(btnc), .btnl(btnl), .btnr(btnr), .btnd(btnd),
        .alu_op(alu_op0), .op_valid(op_valid0), .chord(chord0)
    );

    calc_btn_encoder #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(8)) u_dut_tmo (
        .clk(clk), .rst(rst), .btnc(btnc), .btnl(btnl), .btnr(btnr), .btnd(btnd),
        .alu_op(alu_op1), .op_valid(op_valid1), .chord(chord1)
    );

    always @(posedge clk) begin
        #1;
        if (op_valid0) pulses0++;
        if (op_valid1) pulses1++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [2:0] chord;
        logic [3:0] op;
    } vec_t;

    vec_t vecs[8];

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic enter_pulse(input int n);
        btnd = 1'b1;
        cyc(n);
        btnd = 1'b0;
    endtask

    int  base0, base1;
    logic [2:0] seen;

    initial begin
        vecs[0] = '{3'b000, 4'b0010};
        vecs[1] = '{3'b001, 4'b0110};
        vecs[2] = '{3'b010, 4'b1101};
        vecs[3] = '{3'b011, 4'b0111};
        vecs[4] = '{3'b100, 4'b0000};
        vecs[5] = '{3'b101, 4'b0001};
        vecs[6] = '{3'b110, 4'b1001};
        vecs[7] = '{3'b111, 4'b1010};

        // Long reset with btnc held must not issue anything.
        cyc(1);
        btnc  = 1'b1;
        base0 = pulses0;
        cyc(20);
        check("reset_no_valid", pulses0 - base0, 0);
        check("reset_op_valid", op_valid0, 0);
        check("reset_alu_op", alu_op0, 0);
        check("reset_chord", chord0, 0);
        btnc = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(2);

        // Chord table: hold chord, press enter while held, then release all.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            {btnc, btnl, btnr} = vecs[i].chord;
            cyc(10);
            check($sformatf("tbl%0d_chord", i), chord0, vecs[i].chord);
            base0 = pulses0;
            base1 = pulses1;
            enter_pulse(8);
            {btnc, btnl, btnr} = 3'b000;
            cyc(14);
            check($sformatf("tbl%0d_pulses", i), pulses0 - base0, 1);
            check($sformatf("tbl%0d_alu_op", i), alu_op0, vecs[i].op);
            check($sformatf("tbl%0d_alu_op_tmo", i), alu_op1, vecs[i].op);
            check($sformatf("tbl%0d_pulses_tmo", i), pulses1 - base1, 1);
        end

        // btnl then btnr three cycles later, released before enter.
        do_reset();
        btnl = 1'b1;
        cyc(3);
        btnr = 1'b1;
        cyc(10);
        btnl = 1'b0;
        btnr = 1'b0;
        cyc(10);
        check("lr_chord_after_release", chord0, 3'b011);
        base0 = pulses0;
        enter_pulse(10);
        cyc(12);
        check("lr_pulses", pulses0 - base0, 1);
        check("lr_alu_op", alu_op0, 4'b0111);
        check("lr_chord_cleared", chord0, 0);

        // Enter latency: first sampling edge k, op_valid in cycle after k+6.
        do_reset();
        base0 = pulses0;
        btnd  = 1'b1;
        cyc(6);
        check("lat_not_early", op_valid0, 0);
        cyc(1);
        check("lat_valid", op_valid0, 1);
        check("lat_alu_op", alu_op0, 4'b0010);
        cyc(1);
        check("lat_one_cycle", op_valid0, 0);
        cyc(20);
        check("lat_single_pulse", pulses0 - base0, 1);
        btnd = 1'b0;
        cyc(10);

        // 2-cycle glitches on btnc never debounce.
        do_reset();
        base0 = pulses0;
        seen  = '0;
        for (int i = 0; i < 15; i++) begin
            btnc = ~btnc;
            cyc(1);
            seen |= chord0;
            cyc(1);
            seen |= chord0;
        end
        btnc = 1'b0;
        cyc(8);
        check("glitch_chord", seen, 0);
        check("glitch_no_valid", pulses0 - base0, 0);
        enter_pulse(10);
        cyc(10);
        check("glitch_then_enter", alu_op0, 4'b0010);

        // Timeout discards the chord only in the TIMEOUT_CYCLES=8 instance.
        do_reset();
        btnc = 1'b1;
        cyc(10);
        btnc = 1'b0;
        cyc(12);
        base0 = pulses0;
        base1 = pulses1;
        enter_pulse(10);
        cyc(10);
        check("tmo_alu_op", alu_op1, 4'b0010);
        check("tmo_pulses", pulses1 - base1, 1);
        check("no_tmo_alu_op", alu_op0, 4'b0000);
        check("no_tmo_pulses", pulses0 - base0, 1);

        // Chord button and enter stabilise in the same cycle.
        do_reset();
        base0 = pulses0;
        btnc  = 1'b1;
        btnd  = 1'b1;
        cyc(10);
        btnc = 1'b0;
        btnd = 1'b0;
        cyc(12);
        check("same_cycle_pulses", pulses0 - base0, 1);
        check("same_cycle_alu_op", alu_op0, 4'b0000);

        // Second enter while still in WAIT_REL is ignored.
        do_reset();
        base0 = pulses0;
        btnl  = 1'b1;
        cyc(8);
        enter_pulse(8);
        cyc(8);
        enter_pulse(8);
        btnl = 1'b0;
        cyc(12);
        check("waitrel_pulses", pulses0 - base0, 1);
        check("waitrel_alu_op", alu_op0, 4'b1101);
        enter_pulse(10);
        cyc(10);
        check("after_waitrel_pulses", pulses0 - base0, 2);
        check("after_waitrel_alu_op", alu_op0, 4'b0010);

        // Reset while ARMED clears the chord.
        do_reset();
        btnc = 1'b1;
        cyc(10);
        check("armed_chord", chord0, 3'b100);
        rst = 1'b1;
        cyc(2);
        btnc = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        check("rst_armed_chord", chord0, 0);
        enter_pulse(10);
        cyc(10);
        check("rst_armed_alu_op", alu_op0, 4'b0010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
